// File: rtl/sm_sat_accum.sv
// Sign-magnitude saturating accumulator with a two-stage valid/ready pipeline (S1 command, S2 acc).
// Define SM_SAT_ACCUM_STICKY_SAT_EN to make sat sticky until sat_clr, CLEAR or rst.
module sm_sat_accum #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] acc,
   output logic             sat,
   input  logic             sat_clr
);

   localparam int MW = WIDTH - 1;
   localparam logic [MW-1:0] MAG_MAX = '1;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   logic             s1_valid_q;
   op_e              s1_op_q;
   logic [WIDTH-1:0] s1_operand_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             sat_q, sat_d;

   logic             advance;
   logic             update;
   logic             sa, sb;
   logic [MW-1:0]    ma, mb;
   logic [WIDTH-1:0] sum_w;
   logic             res_sign;
   logic [MW-1:0]    res_mag;
   logic             res_sat;

   // Handshake: a transfer happens on any cycle where valid and ready are both 1; ready never
   // looks at valid. S2 moves when its result is absent or consumed, S1 refills whenever empty or moving.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || advance;
   assign update   = advance && s1_valid_q;

   assign sa    = acc_q[WIDTH-1];
   assign ma    = acc_q[MW-1:0];
   assign mb    = s1_operand_q[MW-1:0];
   assign sb    = (mb == '0) ? 1'b0 : (s1_operand_q[WIDTH-1] ^ (s1_op_q == OP_SUB));
   assign sum_w = {1'b0, ma} + {1'b0, mb};

   always_comb begin
      res_sign = 1'b0;
      res_mag  = '0;
      res_sat  = 1'b0;
      case (s1_op_q)
         OP_ADD, OP_SUB: begin
            if (sa == sb) begin
               res_sign = sa;
               if (sum_w[MW]) begin
                  res_mag = MAG_MAX;
                  res_sat = 1'b1;
               end else begin
                  res_mag = sum_w[MW-1:0];
               end
            end else if (ma >= mb) begin
               res_sign = sa;
               res_mag  = ma - mb;
            end else begin
               res_sign = sb;
               res_mag  = mb - ma;
            end
         end
         OP_LOAD: begin
            res_sign = s1_operand_q[WIDTH-1];
            res_mag  = mb;
         end
         default: begin
            res_sign = 1'b0;
            res_mag  = '0;
         end
      endcase
      // Negative zero is folded to +0 for every operation.
      if (res_mag == '0) res_sign = 1'b0;
   end

   always_comb begin
      acc_d = acc_q;
      if (update) acc_d = {res_sign, res_mag};
   end

`ifdef SM_SAT_ACCUM_STICKY_SAT_EN
   always_comb begin
      sat_d = sat_q;
      if (sat_clr) sat_d = 1'b0;
      if (update) begin
         if (s1_op_q == OP_CLEAR) sat_d = 1'b0;
         else if (res_sat)        sat_d = 1'b1;
      end
   end
`else
   logic unused_sat_clr;
   assign unused_sat_clr = sat_clr;

   always_comb begin
      sat_d = sat_q;
      if (update) sat_d = res_sat;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_op_q      <= OP_ADD;
         s1_operand_q <= '0;
         out_valid_q  <= 1'b0;
         acc_q        <= '0;
         sat_q        <= 1'b0;
      end else begin
         if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               s1_op_q      <= op_e'(op);
               s1_operand_q <= operand;
            end
         end
         if (advance) out_valid_q <= s1_valid_q;
         acc_q <= acc_d;
         sat_q <= sat_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc       = acc_q;
   assign sat       = sat_q;

endmodule
